// File: rtl/uart_pkg.sv
// Shared UART types and default framing constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_frame_state_e;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: oversampled start detect, mid-bit sampling, parity/stop
// checks, and a one-entry valid/ready holding register for the received byte.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 br_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    rx_frame_state_e      state, state_nxt;
    logic [TW-1:0]        tick_cnt, tick_nxt, tick_inc;
    logic [BW-1:0]        bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 perr, perr_nxt;
    logic                 rxs, sample, done, load;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rxs)
    );

    // Once aligned to mid-bit, every full OVERSAMPLE period lands mid-bit again.
    assign tick_inc = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
    assign sample   = br_tick && (tick_cnt == TICK_LAST);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            perr     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
            perr     <= perr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        perr_nxt  = perr;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                tick_nxt = '0;
                bit_nxt  = '0;
                if (!rxs) state_nxt = START;
            end
            START: begin
                if (br_tick) begin
                    if (tick_cnt == TICK_MID) begin
                        tick_nxt  = '0;
                        state_nxt = rxs ? IDLE : DATA;
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
            end
            DATA: begin
                if (br_tick) tick_nxt = tick_inc;
                if (sample) begin
                    shreg_nxt = {rxs, shreg[DATA_BITS-1:1]};
                    if (bit_cnt == BIT_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (br_tick) tick_nxt = tick_inc;
                if (sample) begin
                    perr_nxt  = ^shreg ^ rxs ^ PARITY_ODD;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (br_tick) tick_nxt = tick_inc;
                if (sample) begin
                    done      = 1'b1;
                    state_nxt = rxs ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not look like a fresh start bit.
                tick_nxt = '0;
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign load = done && (!rx_valid || rx_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= done && !load;
            if (load) begin
                rx_data    <= shreg;
                rx_valid   <= 1'b1;
                frame_err  <= ~rxs;
                parity_err <= PARITY_EN ? perr : 1'b0;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: an 8N1 instance and an 8E1 instance checked
// every cycle against a frame-level model keyed on br_tick counts.
module tb_uart_rx_frame;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n, br_tick;
    logic [1:0]      rx, rdy;
    wire  [1:0]      vld, fe, pe, ovr, bsy;
    wire  [1:0][7:0] rxd;

    typedef struct {
        int         inst;
        int         due;
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } frame_t;

    frame_t          pend[$];
    int              n_vec = 0, n_bad = 0, tick_no = 0, cyc = 0, ok = 0, v = 0;
    int              t0[2], rise_tick[2], vrise[2], ovr_cnt[2], cur_due[2];
    logic [1:0]      ev = '0, ef = '0, ep = '0, eo = '0, pv = '0;
    logic [1:0][7:0] ed = '0;
    event            tick_ev;

    uart_rx_frame #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .br_tick(br_tick), .rx(rx[0]),
        .rx_data(rxd[0]), .rx_valid(vld[0]), .rx_ready(rdy[0]),
        .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ovr[0]), .busy(bsy[0]));

    uart_rx_frame #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
        .clk(clk), .reset_n(reset_n), .br_tick(br_tick), .rx(rx[1]),
        .rx_data(rxd[1]), .rx_valid(vld[1]), .rx_ready(rdy[1]),
        .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ovr[1]), .busy(bsy[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Stop bit is sampled half a bit after the start edge plus one bit per
    // data/parity/stop bit, counted in br_ticks from the start edge.
    task automatic send_frame(input int inst, input logic [7:0] d, input logic stop_b,
                              input logic par_b);
        frame_t f;
        int     nb;
        @(tick_ev);
        rx[inst] = 1'b0;
        t0[inst] = tick_no;
        nb       = 8 + inst + 1;
        f.inst   = inst;
        f.due    = tick_no + 8 + 16 * nb;
        f.data   = d;
        f.ferr   = !stop_b;
        f.perr   = (inst == 1) ? ^{d, par_b} : 1'b0;
        pend.push_back(f);
        cur_due[inst] = f.due;
        for (int b = 0; b < 8; b++) begin
            repeat (16) @(tick_ev);
            rx[inst] = d[b];
        end
        if (inst == 1) begin
            repeat (16) @(tick_ev);
            rx[inst] = par_b;
        end
        repeat (16) @(tick_ev);
        rx[inst] = stop_b;
        repeat (16) @(tick_ev);
    endtask

    // Tick generator, reference model and per-cycle comparison.
    initial begin
        logic       tk;
        logic [1:0] r;
        int         hit;
        br_tick = 1'b0;
        forever begin
            @(posedge clk);
            tk = br_tick;
            r  = rdy;
            cyc++;
            if (tk) tick_no++;
            if (!reset_n) begin
                ev = '0; ef = '0; ep = '0; eo = '0; ed = '0;
                pend.delete();
            end else begin
                for (int i = 0; i < 2; i++) begin
                    hit   = -1;
                    eo[i] = 1'b0;
                    if (tk) foreach (pend[j]) if (pend[j].inst == i && pend[j].due == tick_no) hit = j;
                    if (hit >= 0) begin
                        if (!ev[i] || r[i]) begin
                            ev[i] = 1'b1;
                            ed[i] = pend[hit].data;
                            ef[i] = pend[hit].ferr;
                            ep[i] = pend[hit].perr;
                        end else begin
                            eo[i] = 1'b1;
                        end
                        pend.delete(hit);
                    end else if (ev[i] && r[i]) begin
                        ev[i] = 1'b0;
                    end
                end
            end
            #1;
            br_tick = (cyc % 4 == 0);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("i%0d_valid", i), vld[i], ev[i]);
                chk($sformatf("i%0d_data", i), rxd[i], ed[i]);
                chk($sformatf("i%0d_frame_err", i), fe[i], ef[i]);
                chk($sformatf("i%0d_parity_err", i), pe[i], ep[i]);
                chk($sformatf("i%0d_overrun", i), ovr[i], eo[i]);
                if (vld[i] && !pv[i]) begin
                    vrise[i]++;
                    rise_tick[i] = tick_no;
                end
                if (ovr[i]) ovr_cnt[i]++;
                pv[i] = vld[i];
            end
            if (tk) ->tick_ev;
        end
    end

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: sequence incomplete at t=%0t, expected finish earlier", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            t0[i] = 0; rise_tick[i] = 0; vrise[i] = 0; ovr_cnt[i] = 0; cur_due[i] = 0;
        end
        reset_n = 1'b0;
        rx      = 2'b11;
        rdy     = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", vld, 2'b00);
        chk("rst_busy", bsy, 2'b00);
        chk("rst_data0", rxd[0], 8'h00);
        chk("rst_flags", {fe, pe, ovr}, 6'b0);
        reset_n = 1'b1;
        repeat (4) @(tick_ev);

        // 8N1 0xA5, consumer always ready
        send_frame(0, 8'hA5, 1'b1, 1'b0);
        chk("a5_latency", rise_tick[0] - t0[0], 152);
        chk("a5_data", rxd[0], 8'hA5);
        chk("a5_ferr", fe[0], 1'b0);
        chk("a5_perr", pe[0], 1'b0);
        chk("a5_rises", vrise[0], 1);

        // glitch shorter than half a bit is a false start
        v = vrise[0];
        @(tick_ev);
        rx[0] = 1'b0;
        repeat (2) @(tick_ev);
        chk("fs_busy_hi", bsy[0], 1'b1);
        repeat (2) @(tick_ev);
        rx[0] = 1'b1;
        repeat (8) @(tick_ev);
        chk("fs_busy_lo", bsy[0], 1'b0);
        chk("fs_no_valid", vrise[0], v);

        // stop bit 0 followed by a break
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        repeat (40) @(tick_ev);
        chk("brk_busy", bsy[0], 1'b1);
        chk("brk_data", rxd[0], 8'h3C);
        chk("brk_ferr", fe[0], 1'b1);
        chk("brk_rises", vrise[0], v + 1);
        rx[0] = 1'b1;
        repeat (16) @(tick_ev);
        chk("brk_idle", bsy[0], 1'b0);
        send_frame(0, 8'h81, 1'b1, 1'b0);
        chk("x81_data", rxd[0], 8'h81);
        chk("x81_ferr", fe[0], 1'b0);

        // even parity instance
        send_frame(1, 8'h07, 1'b1, 1'b1);
        chk("par_ok_data", rxd[1], 8'h07);
        chk("par_ok_perr", pe[1], 1'b0);
        chk("par_latency", rise_tick[1] - t0[1], 168);
        send_frame(1, 8'h07, 1'b1, 1'b0);
        chk("par_bad_data", rxd[1], 8'h07);
        chk("par_bad_perr", pe[1], 1'b1);
        chk("par_bad_ferr", fe[1], 1'b0);

        // overrun: consumer stalled across two frames
        rdy[0] = 1'b0;
        send_frame(0, 8'h11, 1'b1, 1'b0);
        send_frame(0, 8'h22, 1'b1, 1'b0);
        chk("ovr_data", rxd[0], 8'h11);
        chk("ovr_valid", vld[0], 1'b1);
        chk("ovr_pulses", ovr_cnt[0], 1);
        @(posedge clk);
        #1 rdy[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("drain_valid", vld[0], 1'b0);
        rdy[0] = 1'b0;

        // drain in the same clk as the next completion
        send_frame(0, 8'h33, 1'b1, 1'b0);
        chk("held_data", rxd[0], 8'h33);
        cur_due[0] = 0;
        ok = 0;
        fork
            send_frame(0, 8'h55, 1'b1, 1'b0);
            begin
                for (int k = 0; k < 400 && ok == 0; k++) begin
                    @(tick_ev);
                    if (cur_due[0] != 0 && tick_no == cur_due[0] - 1) ok = 1;
                end
                if (ok == 1) begin
                    repeat (3) @(posedge clk);
                    #1 rdy[0] = 1'b1;
                    @(posedge clk);
                    #1 rdy[0] = 1'b0;
                end
            end
        join
        chk("same_clk_found", ok, 1);
        chk("same_clk_data", rxd[0], 8'h55);
        chk("same_clk_valid", vld[0], 1'b1);
        chk("same_clk_no_ovr", ovr_cnt[0], 1);

        // reset in the middle of the data bits
        @(tick_ev);
        rx[0] = 1'b0;
        repeat (40) @(tick_ev);
        chk("mid_busy", bsy[0], 1'b1);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", vld[0], 1'b0);
        chk("mid_rst_data", rxd[0], 8'h00);
        chk("mid_rst_flags", {fe[0], pe[0], ovr[0]}, 3'b000);
        chk("mid_rst_busy", bsy[0], 1'b0);
        rx[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(tick_ev);
        chk("post_rst_idle", bsy[0], 1'b0);
        rdy[0] = 1'b1;
        send_frame(0, 8'hF0, 1'b1, 1'b0);
        chk("f0_data", rxd[0], 8'hF0);
        chk("f0_ferr", fe[0], 1'b0);
        chk("f0_latency", rise_tick[0] - t0[0], 152);

        repeat (8) @(posedge clk);
        #1;
        chk("pending_empty", pend.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
